// File: rtl/range_pkg.sv
// Shared types for the range alarm: FSM state encoding and event codes
// reported to the host.
package range_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NORMAL = 2'd1,
    ALARM  = 2'd2
  } state_t;

  localparam logic [1:0] EVT_RAISE = 2'b01;
  localparam logic [1:0] EVT_CLEAR = 2'b10;

endpackage

// File: rtl/range_alarm_evt_slot.sv
// Single-entry valid/ready event holding register with a saturating count
// of events lost while the entry was occupied and not being accepted.
module evt_slot #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       load_code,
  input  logic [WIDTH-1:0] load_span,
  input  logic             ready,
  output logic             valid,
  output logic [1:0]       code,
  output logic [WIDTH-1:0] span,
  output logic [CNT_W-1:0] drop_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Room for a new event when empty or when the current one leaves this edge.
  logic room;
  assign room = !valid || ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= 1'b0;
      code     <= '0;
      span     <= '0;
      drop_cnt <= '0;
    end else begin
      if (load && room) begin
        valid <= 1'b1;
        code  <= load_code;
        span  <= load_span;
      end else if (load) begin
        drop_cnt <= sat_inc(drop_cnt);
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/range_alarm.sv
// Debounced over-range alarm with hysteresis on the span of a max/min
// tracker; records peak span while alarmed and posts raise/clear events.
module range_alarm
  import range_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] min,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] thr_hi,
  input  logic [WIDTH-1:0] thr_lo,
  output logic [WIDTH-1:0] span,
  output logic             alarm,
  output logic [WIDTH-1:0] peak,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_span,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [7:0] DEB = 8'(DEBOUNCE);

  function automatic logic [WIDTH-1:0] larger(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t           state, state_nx;
  logic [7:0]       hit_cnt, hit_nx;
  logic             alarm_nx;
  logic [WIDTH-1:0] peak_nx;
  logic [WIDTH-1:0] span_now;
  logic             post;
  logic [1:0]       post_code;
  logic             in_alarm;
  logic             qual;

  // Inverted inputs (tracker not yet seeded) read as zero span.
  assign span_now = (max >= min) ? max - min : '0;

  always_comb begin
    state_nx  = state;
    hit_nx    = hit_cnt;
    alarm_nx  = alarm;
    peak_nx   = peak;
    post      = 1'b0;
    post_code = EVT_RAISE;
    in_alarm  = (state == ALARM);
    qual      = in_alarm ? (span_now < thr_lo) : (span_now > thr_hi);
    if (in_valid) begin
      if (state == IDLE) state_nx = NORMAL;
      if (in_alarm) peak_nx = larger(peak, span_now);
      if (!qual) begin
        hit_nx = '0;
      end else if (hit_cnt + 8'd1 == DEB) begin
        hit_nx = '0;
        post   = 1'b1;
        if (in_alarm) begin
          state_nx  = NORMAL;
          alarm_nx  = 1'b0;
          post_code = EVT_CLEAR;
        end else begin
          state_nx = ALARM;
          alarm_nx = 1'b1;
          peak_nx  = span_now;
        end
      end else begin
        hit_nx = hit_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hit_cnt <= '0;
      alarm   <= 1'b0;
      peak    <= '0;
      span    <= '0;
    end else begin
      state   <= state_nx;
      hit_cnt <= hit_nx;
      alarm   <= alarm_nx;
      peak    <= peak_nx;
      if (in_valid) span <= span_now;
    end
  end

  evt_slot #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_evt_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (post),
    .load_code (post_code),
    .load_span (span_now),
    .ready     (evt_ready),
    .valid     (evt_valid),
    .code      (evt_code),
    .span      (evt_span),
    .drop_cnt  (drop_cnt)
  );

endmodule

// File: tb/tb_range_alarm.sv
// Directed bench for range_alarm: DEBOUNCE 4, thresholds 1000/500.
module tb_range_alarm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] smax, smin, thr_hi, thr_lo;
  logic        in_valid, evt_ready;
  logic [31:0] span, peak, evt_span;
  logic        alarm, evt_valid;
  logic [1:0]  evt_code;
  logic [7:0]  drop_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  range_alarm #(.WIDTH(32), .DEBOUNCE(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .max       (smax),
    .min       (smin),
    .in_valid  (in_valid),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .span      (span),
    .alarm     (alarm),
    .peak      (peak),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_span  (evt_span),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one sample across one rising edge, leave time at edge + 1.
  task automatic sample(input logic [31:0] a, input logic [31:0] b, input logic v);
    smax = a;
    smin = b;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    thr_hi = 32'd1000;
    thr_lo = 32'd500;
    evt_ready = 1'b1;
    smax = 0; smin = 0; in_valid = 0;

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      evt_ready = i[0];
      sample(32'd2000 + i, 32'd0, 1'b1);
    end
    chk("rst_span", span, 0);
    chk("rst_alarm", {31'd0, alarm}, 0);
    chk("rst_peak", peak, 0);
    chk("rst_evt_valid", {31'd0, evt_valid}, 0);
    chk("rst_evt_code", {30'd0, evt_code}, 0);
    chk("rst_evt_span", evt_span, 0);
    chk("rst_drop", {24'd0, drop_cnt}, 0);
    rst = 1'b1;
    evt_ready = 1'b1;

    sample(32'd7, 32'd3, 1'b1);
    chk("first_span", span, 4);
    chk("first_alarm", {31'd0, alarm}, 0);

    // Raise after four qualifying samples
    for (int i = 1; i <= 3; i++) begin
      sample(32'd2000, 32'd0, 1'b1);
      chk("raise_pre_alarm", {31'd0, alarm}, 0);
    end
    sample(32'd2000, 32'd0, 1'b1);
    chk("raise_alarm", {31'd0, alarm}, 1);
    chk("raise_evt_valid", {31'd0, evt_valid}, 1);
    chk("raise_evt_code", {30'd0, evt_code}, 1);
    chk("raise_evt_span", evt_span, 2000);
    chk("raise_peak", peak, 2000);

    // Peak tracking and clear
    sample(32'd3000, 32'd0, 1'b1);
    chk("accept_evt_valid", {31'd0, evt_valid}, 0);
    chk("peak_3000", peak, 3000);
    sample(32'd1500, 32'd0, 1'b1);
    chk("peak_hold", peak, 3000);
    for (int i = 1; i <= 3; i++) begin
      sample(32'd400, 32'd0, 1'b1);
      chk("clear_pre_alarm", {31'd0, alarm}, 1);
    end
    sample(32'd400, 32'd0, 1'b1);
    chk("clear_alarm", {31'd0, alarm}, 0);
    chk("clear_evt_valid", {31'd0, evt_valid}, 1);
    chk("clear_evt_code", {30'd0, evt_code}, 2);
    chk("clear_evt_span", evt_span, 400);
    chk("clear_peak", peak, 3000);

    // Interrupted run does not raise
    for (int i = 0; i < 3; i++) sample(32'd2000, 32'd0, 1'b1);
    sample(32'd100, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) sample(32'd2000, 32'd0, 1'b1);
    chk("interrupt_alarm", {31'd0, alarm}, 0);
    chk("interrupt_evt_valid", {31'd0, evt_valid}, 0);
    sample(32'd100, 32'd0, 1'b1);

    // Back-pressure: raise held, clear dropped
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample(32'd2000, 32'd0, 1'b1);
    chk("bp_raise_valid", {31'd0, evt_valid}, 1);
    for (int i = 0; i < 4; i++) sample(32'd400, 32'd0, 1'b1);
    chk("bp_alarm", {31'd0, alarm}, 0);
    chk("bp_drop1", {24'd0, drop_cnt}, 1);
    chk("bp_hold_code", {30'd0, evt_code}, 1);
    chk("bp_hold_span", evt_span, 2000);
    for (int r = 0; r < 150; r++) begin
      for (int i = 0; i < 4; i++) sample(32'd2000, 32'd0, 1'b1);
      for (int i = 0; i < 4; i++) sample(32'd400, 32'd0, 1'b1);
      if (r == 0) chk("bp_drop3", {24'd0, drop_cnt}, 3);
    end
    chk("bp_drop_sat", {24'd0, drop_cnt}, 255);
    chk("bp_hold_code2", {30'd0, evt_code}, 1);

    // Same-edge accept and new raise event
    for (int i = 0; i < 3; i++) sample(32'd2000, 32'd0, 1'b1);
    evt_ready = 1'b1;
    sample(32'd2500, 32'd0, 1'b1);
    chk("same_edge_valid", {31'd0, evt_valid}, 1);
    chk("same_edge_span", evt_span, 2500);
    chk("same_edge_code", {30'd0, evt_code}, 1);
    chk("same_edge_alarm", {31'd0, alarm}, 1);
    chk("same_edge_drop", {24'd0, drop_cnt}, 255);

    // Inverted input gives zero span, which also clears the alarm
    sample(32'd5, 32'd10, 1'b1);
    chk("inv_span", span, 0);
    chk("inv_accept", {31'd0, evt_valid}, 0);
    for (int i = 0; i < 3; i++) sample(32'd5, 32'd10, 1'b1);
    chk("inv_clear_alarm", {31'd0, alarm}, 0);
    chk("inv_clear_code", {30'd0, evt_code}, 2);
    chk("inv_clear_span", evt_span, 0);
    chk("inv_peak_hold", peak, 2500);

    // Gapped qualifying samples
    sample(32'd2000, 32'd0, 1'b1);
    sample(32'd2000, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) sample(32'd100, 32'd0, 1'b0);
    chk("gap_span_frozen", span, 2000);
    chk("gap_alarm", {31'd0, alarm}, 0);
    sample(32'd2000, 32'd0, 1'b1);
    chk("gap_third_alarm", {31'd0, alarm}, 0);
    sample(32'd2000, 32'd0, 1'b1);
    chk("gap_fourth_alarm", {31'd0, alarm}, 1);
    chk("gap_evt_valid", {31'd0, evt_valid}, 1);

    // Asynchronous reset mid-alarm with an event pending
    evt_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_alarm", {31'd0, alarm}, 0);
    chk("async_evt_valid", {31'd0, evt_valid}, 0);
    chk("async_peak", peak, 0);
    chk("async_drop", {24'd0, drop_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample(32'd100, 32'd0, 1'b1);
      chk("post_rst_evt_valid", {31'd0, evt_valid}, 0);
    end
    chk("post_rst_span", span, 100);
    chk("post_rst_alarm", {31'd0, alarm}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/range_alarm.md
# range_alarm

Downstream consumer of the `maxmin` tracker: takes its running `max`/`min` each cycle, forms the span (max − min), and raises a debounced over-range alarm with hysteresis. Records the peak span while alarmed and reports raise/clear events to a host through a single-entry valid/ready event slot.

## Interface

Parameters:
- `WIDTH`, 32: data width, matches `maxmin` outputs
- `DEBOUNCE`, 4: consecutive qualifying valid samples needed to raise or clear; range 1..255
- `CNT_W`, 8: width of the dropped-event counter

Ports (one clock; reset asynchronous, active-low):
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `max` in WIDTH: running maximum from `maxmin`
- `min` in WIDTH: running minimum from `maxmin`
- `in_valid` in 1: sample qualifier; tie high for a free-running upstream
- `thr_hi` in WIDTH: raise threshold (span > thr_hi qualifies)
- `thr_lo` in WIDTH: clear threshold (span < thr_lo qualifies)
- `span` out WIDTH: registered span of the last valid sample
- `alarm` out 1: alarm level
- `peak` out WIDTH: maximum span seen since the alarm was raised
- `evt_valid` out 1: event pending
- `evt_ready` in 1: host accepts the event
- `evt_code` out 2: 01 = raise, 10 = clear
- `evt_span` out WIDTH: span that triggered the event
- `drop_cnt` out CNT_W: events lost because the slot was full; saturating

## Operation

- Span, all unsigned: `max >= min ? max − min : 0`. The 0 case covers the pre-first-sample `maxmin` state.
- All state advances only on edges where `in_valid = 1`. Invalid cycles freeze the counters and the FSM.
- FSM states:
  - IDLE: left on the first valid sample, to NORMAL. That sample is also evaluated as a NORMAL sample.
  - NORMAL: `hit_cnt` increments on each valid sample with span > thr_hi and resets to 0 on any valid non-qualifying sample. When the count reaches DEBOUNCE: go to ALARM, `alarm` = 1, `peak` = span, post a raise event, `hit_cnt` = 0.
  - ALARM: `peak` = max(peak, span) on each valid sample. `hit_cnt` counts valid samples with span < thr_lo and resets otherwise. At DEBOUNCE: go to NORMAL, `alarm` = 0, post a clear event, `hit_cnt` = 0. `peak` holds its value until the next raise.
- Misconfiguration (thr_lo > thr_hi) is not checked; the rules above still apply literally.
- Event slot rules:
  - New event with the slot empty: load it and set `evt_valid`.
  - Slot full with `evt_ready` = 0: drop the new event and increment `drop_cnt`, saturating at 2^CNT_W − 1.
  - Same-edge accept and new event: the new event is loaded and `evt_valid` stays 1.
  - `evt_code` and `evt_span` are stable while `evt_valid` = 1.

## Timing

- Reset (async assert, sync use after release) sets: state IDLE, `span` 0, `alarm` 0, `peak` 0, `evt_valid` 0, `evt_code` 0, `evt_span` 0, `drop_cnt` 0, `hit_cnt` 0.
- Reset mid-operation discards any pending event and clears the alarm without posting a clear event.
- `span` latency is 1 cycle: valid sample at edge N is visible after edge N.
- `alarm` and `evt_valid` rise or fall at the same edge that captures the DEBOUNCE-th qualifying sample. There is no extra pipeline stage.
- An event is accepted at an edge with `evt_valid` = 1 and `evt_ready` = 1. `evt_valid` drops after that edge unless a new event loads on the same edge.
- `evt_ready` has no combinational path to any output.

## Structure

- Package `range_pkg`: state enum (IDLE, NORMAL, ALARM), event code constants `EVT_RAISE` = 2'b01 and `EVT_CLEAR` = 2'b10.
- Sub-module `evt_slot`: single-entry valid/ready holding register plus the saturating drop counter, parameterised on WIDTH and CNT_W.
- FSM, span computation and peak tracking live in the `range_alarm` top.

## Test plan

All scenarios use DEBOUNCE = 4, thr_hi = 1000, thr_lo = 500, `evt_ready` = 1 unless stated.

- Reset: hold `rst` low while toggling all inputs -> every output stays 0. Release, apply max = 7, min = 3 -> `span` = 4 next cycle, `alarm` = 0.
- Raise: max = 2000, min = 0 valid for 4 cycles -> `alarm` and `evt_valid` rise on edge 4 with `evt_code` = 01, `evt_span` = 2000. Three qualifying samples followed by span 100 -> no alarm.
- Peak and clear: in ALARM, spans 3000, 1500, then 400 ×4 -> `peak` = 3000; `alarm` falls on the 4th 400 sample; clear event posted with `evt_span` = 400.
- Back-pressure: `evt_ready` = 0, run raise then clear -> slot holds the raise event, `drop_cnt` = 1. Force 300 drops -> `drop_cnt` saturates at 255.
- Inverted and gapped input: max = 5, min = 10 -> `span` = 0. Two qualifying samples, 3 cycles `in_valid` = 0, two more qualifying -> alarm on the 4th valid sample.
- Reset mid-alarm: assert `rst` with `evt_valid` = 1 and `alarm` = 1 -> both 0 immediately (async). No clear event after release.
